// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared types and default parameters for the data-cache
//                sequencing controller.
//  Contents    : cache_state_e        - controller state encoding
//                DEFAULT_TIMEOUT_CYC  - default memory-ack wait limit
//                DEFAULT_CNT_W        - default read-miss counter width
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_MEM_RD  = 3'd2,
        ST_REFILL  = 3'd3,
        ST_MEM_WR  = 3'd4,
        ST_RESPOND = 3'd5
    } cache_state_e;

    localparam int DEFAULT_TIMEOUT_CYC = 256;
    localparam int DEFAULT_CNT_W       = 16;

endpackage
`default_nettype wire

// File: rtl/cache_timeout_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : cache_timeout_cnt
//  Description : Wait-cycle counter for an outstanding memory request.
//                o_expired is high while the count equals LIMIT-1, i.e. on
//                the LIMIT-th cycle of waiting since the last clear.
//  Ports       : clk_i     - clock
//                rst_ni    - asynchronous active-low reset
//                i_clear   - synchronous clear (has priority over i_en)
//                i_en      - count one more waited cycle
//                o_expired - wait limit reached this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_timeout_cnt #(
    parameter int LIMIT = 256   // must be >= 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam int CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == c_last_cnt);

endmodule
`default_nettype wire

// File: rtl/cache_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : cache_ctrl_fsm
//  Description : Data-cache sequencing controller. Write-through,
//                read-allocate, write-no-allocate, one request in flight.
//                Owns lookup / miss / refill / write-through flow, array
//                write strobes and the memory request handshake.
//  Ports       : clk_i, rst_ni            - clock, async active-low reset
//                cpu_req_i/we_i/addr_i    - pipeline request (held to ready)
//                hit_i                    - tag compare, valid in LOOKUP
//                mem_ack_i                - 1-cycle memory completion
//                mem_req_o/we_o/addr_o    - memory request (level)
//                data_we_o, tag_we_o      - array write strobes
//                out_en_no                - active-low output-register enable
//                cpu_ready_o, cpu_stall_o - pipeline completion / stall
//                miss_cnt_o               - saturating read-miss count
//                timeout_err_o            - sticky memory timeout flag
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_ctrl_fsm
    import cache_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cpu_req_i,
    input  logic             cpu_we_i,
    input  logic [31:0]      cpu_addr_i,
    input  logic             hit_i,
    input  logic             mem_ack_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic             data_we_o,
    output logic             tag_we_o,
    output logic             out_en_no,
    output logic             cpu_ready_o,
    output logic             cpu_stall_o,
    output logic [CNT_W-1:0] miss_cnt_o,
    output logic             timeout_err_o
);

    cache_state_e     r_state;
    cache_state_e     w_next;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [CNT_W-1:0] r_miss_cnt;
    logic             r_timeout_err;
    logic             w_wait;
    logic             w_expired;
    logic             w_miss_inc;
    logic             w_set_err;

    assign w_wait = (r_state == ST_MEM_RD) || (r_state == ST_MEM_WR);

    // Held in clear outside the wait states, so each wait starts from zero.
    cache_timeout_cnt #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .i_clear   (!w_wait),
        .i_en      (w_wait && !mem_ack_i),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        data_we_o   = 1'b0;
        tag_we_o    = 1'b0;
        out_en_no   = 1'b1;
        cpu_ready_o = 1'b0;
        cpu_stall_o = 1'b0;
        w_miss_inc  = 1'b0;
        w_set_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cpu_req_i) w_next = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                cpu_stall_o = 1'b1;
                if (r_we) begin
                    // Store hit updates the line now; misses do not allocate.
                    data_we_o = hit_i;
                    w_next    = ST_MEM_WR;
                end else if (hit_i) begin
                    w_next = ST_RESPOND;
                end else begin
                    w_miss_inc = 1'b1;
                    w_next     = ST_MEM_RD;
                end
            end
            ST_MEM_RD: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                // Ack on the limit cycle takes the normal path.
                if (mem_ack_i) begin
                    w_next = ST_REFILL;
                end else if (w_expired) begin
                    w_set_err = 1'b1;
                    w_next    = ST_RESPOND;
                end
            end
            ST_REFILL: begin
                cpu_stall_o = 1'b1;
                data_we_o   = 1'b1;
                tag_we_o    = 1'b1;
                w_next      = ST_RESPOND;
            end
            ST_MEM_WR: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                if (mem_ack_i) begin
                    w_next = ST_RESPOND;
                end else if (w_expired) begin
                    w_set_err = 1'b1;
                    w_next    = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                out_en_no   = 1'b0;
                cpu_ready_o = 1'b1;
                w_next      = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Request is captured once at acceptance; later input changes are ignored.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr <= '0;
            r_we   <= 1'b0;
        end else if ((r_state == ST_IDLE) && cpu_req_i) begin
            r_addr <= cpu_addr_i;
            r_we   <= cpu_we_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_miss_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_miss_inc && (r_miss_cnt != {CNT_W{1'b1}})) begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
            end
            if (w_set_err) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign mem_addr_o    = r_addr;
    assign miss_cnt_o    = r_miss_cnt;
    assign timeout_err_o = r_timeout_err;

endmodule
`default_nettype wire
